// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block feeder.
package aes_pkg;

  localparam int AES_BLK_W     = 128;
  localparam int AES_WORD_W    = 32;
  localparam int WORDS_PER_BLK = 4;

  // Feeder control states: gather words, fire the core, wait for it.
  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2
  } feed_state_e;

  // A word closes its block when it fills the last slot or ends the message.
  function automatic logic is_final_word(input logic [1:0] idx, input logic last);
    return (idx == 2'd3) || last;
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Packs 32-bit words big-endian into a 128-bit block; zero-fills the tail
// of a block cut short by the message's last word.
module aes_word_packer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [AES_WORD_W-1:0] word,
  input  logic                  last,
  output logic [AES_BLK_W-1:0]  blk,
  output logic [1:0]            idx,
  output logic                  blk_done,
  output logic                  blk_partial
);

  logic [1:0]           idx_r;
  logic [1:0]           idx_next_s;
  logic [AES_BLK_W-1:0] blk_r;
  logic [AES_BLK_W-1:0] blk_next_s;
  logic                 final_s;

  // Next block contents and word index for the current transfer.
  always_comb begin
    final_s    = is_final_word(idx_r, last);
    blk_next_s = blk_r;
    idx_next_s = idx_r;
    if (accept) begin
      for (int j = 0; j < WORDS_PER_BLK; j++) begin
        if (2'(j) == idx_r) begin
          blk_next_s[AES_BLK_W-1-AES_WORD_W*j -: AES_WORD_W] = word;
        end else if (last && (2'(j) > idx_r)) begin
          blk_next_s[AES_BLK_W-1-AES_WORD_W*j -: AES_WORD_W] = {AES_WORD_W{1'b0}};
        end else begin
          blk_next_s[AES_BLK_W-1-AES_WORD_W*j -: AES_WORD_W] = blk_r[AES_BLK_W-1-AES_WORD_W*j -: AES_WORD_W];
        end
      end
      idx_next_s = final_s ? 2'd0 : (idx_r + 2'd1);
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Assembly register and index; reset discards any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= 2'd0;
      blk_r <= {AES_BLK_W{1'b0}};
    end else begin
      idx_r <= idx_next_s;
      blk_r <= blk_next_s;
    end
  end

  assign blk         = blk_r;
  assign idx         = idx_r;
  assign blk_done    = accept && final_s;
  assign blk_partial = accept && last && (idx_r != 2'd3);

endmodule

// File: rtl/aes_block_feeder.sv
// Streams 32-bit words into 128-bit blocks and hands each block to an AES
// core with a start pulse, chaining flag and bounded wait for completion.
module aes_block_feeder
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                  aes_clk,
  input  logic                  aes_rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [AES_WORD_W-1:0] s_data,
  input  logic                  s_last,
  input  logic                  cfg_decipher,
  output logic [AES_BLK_W-1:0]  aes_data_in,
  output logic                  aes_cipher_en,
  output logic                  aes_decipher_en,
  output logic                  aes_chain_en,
  input  logic                  aes_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      blk_cnt,
  output logic                  err_partial,
  output logic                  err_timeout
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  feed_state_e      state_r, state_next_s;
  logic             s_ready_r, busy_r, cipher_en_r, decipher_en_r, chain_en_r;
  logic             mode_r, mode_next_s;
  logic             first_flag_r, first_flag_next_s;
  logic             err_partial_r, err_partial_next_s;
  logic             err_timeout_r, err_timeout_next_s;
  logic             chain_next_s;
  logic [CNT_W-1:0] blk_cnt_r, cnt_base_s, cnt_next_s;
  logic [TMO_W-1:0] tmo_r, tmo_next_s;
  logic             accept_s, first_word_s, issue_start_s, tmo_fire_s;
  logic [1:0]       pk_idx_s;
  logic             pk_done_s, pk_partial_s;

  assign accept_s = s_valid && s_ready_r;

  aes_word_packer u_packer (
    .clk         (aes_clk),
    .rst         (aes_rst),
    .accept      (accept_s),
    .word        (s_data),
    .last        (s_last),
    .blk         (aes_data_in),
    .idx         (pk_idx_s),
    .blk_done    (pk_done_s),
    .blk_partial (pk_partial_s)
  );

  // Next state plus next values of every flag, counter and output.
  always_comb begin
    state_next_s = state_r;
    tmo_fire_s   = 1'b0;
    first_word_s = accept_s && first_flag_r && (pk_idx_s == 2'd0);
    mode_next_s  = first_word_s ? cfg_decipher : mode_r;
    case (state_r)
      ST_COLLECT: begin
        if (pk_done_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (aes_ready) begin
          state_next_s = ST_COLLECT;
        end else if (tmo_r == TMO_LAST) begin
          state_next_s = ST_COLLECT;
          tmo_fire_s   = 1'b1;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: state_next_s = ST_COLLECT;
    endcase

    issue_start_s = (state_r == ST_COLLECT) && (state_next_s == ST_ISSUE);
    tmo_next_s    = (state_r == ST_WAIT) ? (tmo_r + TMO_W'(1)) : {TMO_W{1'b0}};

    // The final word's s_last decides whether the next block starts a new chain.
    if (tmo_fire_s) begin
      first_flag_next_s = 1'b1;
    end else if (issue_start_s) begin
      first_flag_next_s = s_last;
    end else begin
      first_flag_next_s = first_flag_r;
    end

    chain_next_s = issue_start_s ? !first_flag_r : chain_en_r;

    cnt_base_s = first_word_s ? {CNT_W{1'b0}} : blk_cnt_r;
    if (issue_start_s && (cnt_base_s != {CNT_W{1'b1}})) begin
      cnt_next_s = cnt_base_s + CNT_W'(1);
    end else begin
      cnt_next_s = cnt_base_s;
    end

    if (pk_partial_s) begin
      err_partial_next_s = 1'b1;
    end else if (first_word_s) begin
      err_partial_next_s = 1'b0;
    end else begin
      err_partial_next_s = err_partial_r;
    end

    if (tmo_fire_s) begin
      err_timeout_next_s = 1'b1;
    end else if (first_word_s) begin
      err_timeout_next_s = 1'b0;
    end else begin
      err_timeout_next_s = err_timeout_r;
    end
  end

  // State and registered outputs; pulses are registered off the next state.
  always_ff @(posedge aes_clk) begin
    if (aes_rst) begin
      state_r       <= ST_COLLECT;
      s_ready_r     <= 1'b0;
      busy_r        <= 1'b0;
      cipher_en_r   <= 1'b0;
      decipher_en_r <= 1'b0;
      chain_en_r    <= 1'b0;
      mode_r        <= 1'b0;
      first_flag_r  <= 1'b1;
      err_partial_r <= 1'b0;
      err_timeout_r <= 1'b0;
      blk_cnt_r     <= {CNT_W{1'b0}};
      tmo_r         <= {TMO_W{1'b0}};
    end else begin
      state_r       <= state_next_s;
      s_ready_r     <= (state_next_s == ST_COLLECT);
      busy_r        <= (state_next_s != ST_COLLECT);
      cipher_en_r   <= issue_start_s && !mode_next_s;
      decipher_en_r <= issue_start_s && mode_next_s;
      chain_en_r    <= chain_next_s;
      mode_r        <= mode_next_s;
      first_flag_r  <= first_flag_next_s;
      err_partial_r <= err_partial_next_s;
      err_timeout_r <= err_timeout_next_s;
      blk_cnt_r     <= cnt_next_s;
      tmo_r         <= tmo_next_s;
    end
  end

  assign s_ready         = s_ready_r;
  assign busy            = busy_r;
  assign aes_cipher_en   = cipher_en_r;
  assign aes_decipher_en = decipher_en_r;
  assign aes_chain_en    = chain_en_r;
  assign blk_cnt         = blk_cnt_r;
  assign err_partial     = err_partial_r;
  assign err_timeout     = err_timeout_r;

endmodule

// File: tb/tb_aes_block_feeder.sv
// Directed self-checking bench for aes_block_feeder.
module tb_aes_block_feeder;

  logic         aes_clk;
  logic         aes_rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic         cfg_decipher;
  logic [127:0] aes_data_in;
  logic         aes_cipher_en;
  logic         aes_decipher_en;
  logic         aes_chain_en;
  logic         aes_ready;
  logic         busy;
  logic [15:0]  blk_cnt;
  logic         err_partial;
  logic         err_timeout;

  int n_chk;
  int n_fail;

  aes_block_feeder #(.TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .aes_clk         (aes_clk),
    .aes_rst         (aes_rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_last          (s_last),
    .cfg_decipher    (cfg_decipher),
    .aes_data_in     (aes_data_in),
    .aes_cipher_en   (aes_cipher_en),
    .aes_decipher_en (aes_decipher_en),
    .aes_chain_en    (aes_chain_en),
    .aes_ready       (aes_ready),
    .busy            (busy),
    .blk_cnt         (blk_cnt),
    .err_partial     (err_partial),
    .err_timeout     (err_timeout)
  );

  initial aes_clk = 1'b0;
  always #5 aes_clk = ~aes_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] d, input logic last, input logic dec);
    int wait_cyc;
    @(negedge aes_clk);
    s_valid      = 1'b1;
    s_data       = d;
    s_last       = last;
    cfg_decipher = dec;
    wait_cyc     = 0;
    while (s_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge aes_clk);
      wait_cyc++;
    end
    if (wait_cyc >= 50) begin
      chk("send_ready_timeout", {127'd0, s_ready}, 128'd1);
    end
    @(posedge aes_clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called at the ISSUE-cycle negedge: raise aes_ready dly cycles later for one cycle.
  task automatic respond(input int dly);
    repeat (dly) @(negedge aes_clk);
    aes_ready = 1'b1;
    @(negedge aes_clk);
    aes_ready = 1'b0;
  endtask

  logic [31:0]  w [0:11];
  logic [127:0] exp_blk;

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    aes_rst      = 1'b1;
    s_valid      = 1'b0;
    s_data       = 32'd0;
    s_last       = 1'b0;
    cfg_decipher = 1'b0;
    aes_ready    = 1'b0;
    for (int i = 0; i < 12; i++) w[i] = 32'hA000_0000 + 32'(i);

    // Reset state
    repeat (3) @(posedge aes_clk);
    @(negedge aes_clk);
    chk("rst_data", aes_data_in, 128'd0);
    chk("rst_pulses", {126'd0, aes_cipher_en, aes_decipher_en}, 128'd0);
    chk("rst_flags", {124'd0, aes_chain_en, busy, err_partial, err_timeout}, 128'd0);
    chk("rst_cnt", {112'd0, blk_cnt}, 128'd0);
    aes_rst = 1'b0;
    @(negedge aes_clk);
    chk("rst_rel_ready", {127'd0, s_ready}, 128'd1);

    // Single full block, cipher
    send(32'h0011_2233, 1'b0, 1'b0);
    send(32'h4455_6677, 1'b0, 1'b0);
    send(32'h8899_AABB, 1'b0, 1'b0);
    send(32'hCCDD_EEFF, 1'b1, 1'b0);
    @(negedge aes_clk);
    chk("b1_cipher_en", {127'd0, aes_cipher_en}, 128'd1);
    chk("b1_decipher_en", {127'd0, aes_decipher_en}, 128'd0);
    chk("b1_data", aes_data_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("b1_chain", {127'd0, aes_chain_en}, 128'd0);
    chk("b1_cnt", {112'd0, blk_cnt}, 128'd1);
    chk("b1_issue_busy", {126'd0, s_ready, busy}, 128'd1);
    aes_ready = 1'b1;  // in the ISSUE cycle: must be ignored
    @(negedge aes_clk);
    aes_ready = 1'b0;
    chk("b1_wait_pulse_low", {127'd0, aes_cipher_en}, 128'd0);
    chk("b1_ready_in_issue_ignored", {126'd0, s_ready, busy}, 128'd1);
    chk("b1_wait_data", aes_data_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    respond(0);
    chk("b1_back_collect", {126'd0, s_ready, busy}, 128'd2);

    // Three-block chained message, aes_ready 5 cycles after each ISSUE
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 4; k++) send(w[4*b+k], (b == 2 && k == 3), 1'b0);
      @(negedge aes_clk);
      chk($sformatf("m3_b%0d_pulse", b), {127'd0, aes_cipher_en}, 128'd1);
      chk($sformatf("m3_b%0d_chain", b), {127'd0, aes_chain_en}, (b == 0) ? 128'd0 : 128'd1);
      chk($sformatf("m3_b%0d_cnt", b), {112'd0, blk_cnt}, 128'(b + 1));
      chk($sformatf("m3_b%0d_sready_issue", b), {127'd0, s_ready}, 128'd0);
      @(negedge aes_clk);
      chk($sformatf("m3_b%0d_sready_wait", b), {127'd0, s_ready}, 128'd0);
      chk($sformatf("m3_b%0d_chain_hold", b), {127'd0, aes_chain_en}, (b == 0) ? 128'd0 : 128'd1);
      respond(4);
    end
    exp_blk = {w[8], w[9], w[10], w[11]};
    chk("m3_last_data", aes_data_in, exp_blk);
    chk("m3_cnt_final", {112'd0, blk_cnt}, 128'd3);

    // Partial block, decipher
    send(32'h1234_5678, 1'b0, 1'b1);
    send(32'h9ABC_DEF0, 1'b1, 1'b1);
    @(negedge aes_clk);
    chk("p_decipher_en", {127'd0, aes_decipher_en}, 128'd1);
    chk("p_cipher_en", {127'd0, aes_cipher_en}, 128'd0);
    chk("p_data", aes_data_in, 128'h12345678_9ABCDEF0_00000000_00000000);
    chk("p_err_partial", {127'd0, err_partial}, 128'd1);
    chk("p_chain", {127'd0, aes_chain_en}, 128'd0);
    chk("p_cnt", {112'd0, blk_cnt}, 128'd1);
    respond(1);
    chk("p_err_sticky", {127'd0, err_partial}, 128'd1);

    // Timeout: aes_ready never comes
    for (int k = 0; k < 4; k++) send(32'h5500_0000 + 32'(k), 1'b0, 1'b0);
    @(negedge aes_clk);
    chk("t_pulse", {127'd0, aes_cipher_en}, 128'd1);
    chk("t_err_partial_cleared", {127'd0, err_partial}, 128'd0);
    repeat (8) @(negedge aes_clk);
    chk("t_still_wait_8th", {126'd0, busy, err_timeout}, 128'd2);
    @(negedge aes_clk);
    chk("t_err_timeout", {127'd0, err_timeout}, 128'd1);
    chk("t_back_collect", {126'd0, s_ready, busy}, 128'd2);
    for (int k = 0; k < 4; k++) send(32'h6600_0000 + 32'(k), 1'b0, 1'b0);
    @(negedge aes_clk);
    chk("t_next_chain", {127'd0, aes_chain_en}, 128'd0);
    chk("t_err_timeout_cleared", {127'd0, err_timeout}, 128'd0);
    chk("t_next_cnt", {112'd0, blk_cnt}, 128'd1);
    respond(1);

    // Reset mid-block (first_flag is 0 here, mid message)
    send(32'hDEAD_0001, 1'b0, 1'b0);
    send(32'hDEAD_0002, 1'b0, 1'b0);
    @(negedge aes_clk);
    aes_rst = 1'b1;
    @(negedge aes_clk);
    chk("r_data", aes_data_in, 128'd0);
    chk("r_flags", {122'd0, s_ready, busy, aes_cipher_en, aes_chain_en, err_partial, err_timeout}, 128'd0);
    chk("r_cnt", {112'd0, blk_cnt}, 128'd0);
    aes_rst = 1'b0;
    @(negedge aes_clk);
    chk("r_rel_ready", {127'd0, s_ready}, 128'd1);
    send(32'h0BAD_0000, 1'b0, 1'b0);
    send(32'h0BAD_0001, 1'b0, 1'b0);
    send(32'h0BAD_0002, 1'b0, 1'b0);
    send(32'h0BAD_0003, 1'b1, 1'b0);
    @(negedge aes_clk);
    chk("r_fresh_pulse", {127'd0, aes_cipher_en}, 128'd1);
    chk("r_fresh_data", aes_data_in, 128'h0BAD0000_0BAD0001_0BAD0002_0BAD0003);
    chk("r_fresh_chain", {127'd0, aes_chain_en}, 128'd0);
    chk("r_fresh_cnt", {112'd0, blk_cnt}, 128'd1);
    respond(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_feeder.md
AES_BLOCK_FEEDER -- requirements
Module: aes_block_feeder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024: max cycles in WAIT for aes_ready before abort.
REQ-002 Parameter CNT_W, default 16: width of blk_cnt.
REQ-003 aes_clk  in  1  sole clock; all logic on the rising edge.
REQ-004 aes_rst  in  1  reset, synchronous, active-high.
REQ-005 s_valid  in  1  upstream word valid.
REQ-006 s_ready  out  1  feeder accepts word; transfer = s_valid & s_ready.
REQ-007 s_data  in  32  plaintext/ciphertext word.
REQ-008 s_last  in  1  last word of message (end of chain).
REQ-009 cfg_decipher  in  1  0 = cipher, 1 = decipher; sampled on first word of each message.
REQ-010 aes_data_in  out  128  assembled block to AES core.
REQ-011 aes_cipher_en  out  1  one-cycle start pulse, cipher.
REQ-012 aes_decipher_en  out  1  one-cycle start pulse, decipher.
REQ-013 aes_chain_en  out  1  0 for first block of message, 1 for later blocks.
REQ-014 aes_ready  in  1  AES core done; sampled only in WAIT.
REQ-015 busy  out  1  high in ISSUE or WAIT.
REQ-016 blk_cnt  out  CNT_W  blocks issued in current message.
REQ-017 err_partial  out  1  sticky: message ended mid-block.
REQ-018 err_timeout  out  1  sticky: aes_ready not seen within TIMEOUT_CYC.

Function
REQ-019 FSM states COLLECT, ISSUE, WAIT; s_ready = 1 only in COLLECT.
REQ-020 COLLECT: word index 0..3; word k stored in aes_data_in[127-32k -: 32] (big-endian).
REQ-021 COLLECT -> ISSUE on transfer with index 3 or s_last; index returns to 0.
REQ-022 s_last at index <3: remaining words zero-filled; err_partial set.
REQ-023 ISSUE lasts exactly one cycle: aes_cipher_en (mode latched 0) or aes_decipher_en (mode latched 1) = 1, never both; then -> WAIT.
REQ-024 aes_chain_en valid in ISSUE and held through WAIT; = !first_flag; first_flag set at reset and after a last block, cleared after issuing any non-last block.
REQ-025 blk_cnt increments in ISSUE, saturates at all-ones, clears on first word of next message.
REQ-026 aes_data_in and aes_chain_en stable from ISSUE until leaving WAIT.
REQ-027 WAIT -> COLLECT on aes_ready = 1; aes_ready in same cycle as ISSUE pulse ignored.
REQ-028 WAIT timeout counter starts at 0 on entry; reaching TIMEOUT_CYC sets err_timeout, forces first_flag = 1, -> COLLECT.
REQ-029 Latency: ISSUE pulse exactly 1 cycle after the accepting cycle of the block's final word.
REQ-030 err_partial and err_timeout cleared on first word of next message.

Reset
REQ-031 aes_rst = 1 (any state, mid-block included): state COLLECT, index 0, first_flag 1, all outputs 0 except s_ready = 1 after reset release; aes_data_in = 0; partial block discarded.

Structure
REQ-032 aes_pkg holds state enum, AES_BLK_W = 128, AES_WORD_W = 32, WORDS_PER_BLK = 4.
REQ-033 One sub-module aes_word_packer: index counter, 128-bit assembly register, zero-fill on s_last.

Verification
REQ-034 Reset, then 4 words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF, s_last on 4th, cfg_decipher=0 -> next-cycle aes_cipher_en pulse, aes_data_in = 0x00112233_44556677_8899AABB_CCDDEEFF, aes_chain_en=0, blk_cnt=1.
REQ-035 Message of 12 words, aes_ready 5 cycles after each ISSUE -> 3 pulses, aes_chain_en 0,1,1; s_ready low in ISSUE/WAIT; blk_cnt=3.
REQ-036 2 words then s_last, cfg_decipher=1 -> aes_decipher_en pulse, low 64 bits zero, err_partial=1.
REQ-037 aes_ready held 0 with TIMEOUT_CYC=8 -> err_timeout after 8 WAIT cycles, return to COLLECT, next block aes_chain_en=0.
REQ-038 aes_rst asserted after 2nd word of block -> all outputs 0, next 4 words form a fresh block with aes_chain_en=0.
